// File: rtl/fp_mul_param.sv
// Parametrised IEEE-754 binary multiplier built as a multi-cycle FSM:
// unpack, normalise, multiply, denormalise, round. One operation in flight at a time.
module fp_mul_param #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [1:0]             in_rm,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [EXP_W+MAN_W:0]   out_z,
  output logic [3:0]             out_flags,
  output logic                   out_valid,
  input  logic                   out_ready
);
  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned SW  = MAN_W + 1;
  localparam int unsigned PW  = 2 * SW;
  localparam int unsigned EW  = EXP_W + 2;
  localparam int unsigned CAP = MAN_W + 3;
  localparam int unsigned CW  = $clog2(CAP + 1);
  localparam int          BIAS_I = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [EW-1:0] BIAS = EW'(BIAS_I);
  localparam logic signed [EW-1:0] EMIN = EW'(1 - BIAS_I);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle, StUnpack, StNorm, StMult, StDenorm, StRound, StOut
  } state_e;

  state_e                r_state, w_state_nxt;
  logic                  r_in_ready;
  logic [W-1:0]          r_a, r_b, r_z;
  logic [3:0]            r_flags;
  logic [1:0]            r_rm;
  logic                  r_sign;
  logic [SW-1:0]         r_ma, r_mb, r_sig;
  logic signed [EW-1:0]  r_ea, r_eb, r_ez;
  logic                  r_g, r_r, r_s;
  logic [CW-1:0]         r_cnt;

  // Unpack
  logic [EXP_W-1:0]      w_ea_fld, w_eb_fld;
  logic [MAN_W-1:0]      w_fa, w_fb;
  logic                  w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic                  w_a_snan, w_b_snan, w_sign, w_special;
  logic signed [EW-1:0]  w_ea_unb, w_eb_unb;
  logic [W-1:0]          w_special_z;
  logic [3:0]            w_special_f;

  assign w_ea_fld = r_a[W-2:MAN_W];
  assign w_eb_fld = r_b[W-2:MAN_W];
  assign w_fa     = r_a[MAN_W-1:0];
  assign w_fb     = r_b[MAN_W-1:0];
  assign w_a_nan  = (&w_ea_fld) & (|w_fa);
  assign w_b_nan  = (&w_eb_fld) & (|w_fb);
  assign w_a_inf  = (&w_ea_fld) & ~(|w_fa);
  assign w_b_inf  = (&w_eb_fld) & ~(|w_fb);
  assign w_a_zero = ~(|w_ea_fld) & ~(|w_fa);
  assign w_b_zero = ~(|w_eb_fld) & ~(|w_fb);
  assign w_a_snan = w_a_nan & ~w_fa[MAN_W-1];
  assign w_b_snan = w_b_nan & ~w_fb[MAN_W-1];
  assign w_sign   = r_a[W-1] ^ r_b[W-1];
  assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
  assign w_ea_unb = (w_ea_fld == '0) ? EMIN : $signed({2'b00, w_ea_fld}) - BIAS;
  assign w_eb_unb = (w_eb_fld == '0) ? EMIN : $signed({2'b00, w_eb_fld}) - BIAS;

  always_comb begin
    w_special_z = '0;
    w_special_f = '0;
    if (w_a_nan | w_b_nan) begin
      w_special_z = QNAN;
      w_special_f = {w_a_snan | w_b_snan, 3'b000};
    end else if ((w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) begin
      w_special_z = QNAN;
      w_special_f = 4'b1000;
    end else if (w_a_inf | w_b_inf) begin
      w_special_z = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else begin
      w_special_z = {w_sign, {(W-1){1'b0}}};
    end
  end

  // Normalise, multiply
  logic [SW-1:0]         w_ma_n, w_mb_n;
  logic signed [EW-1:0]  w_ea_n, w_eb_n, w_ez_m;
  logic [PW-1:0]         w_prod, w_pn;

  assign w_ma_n = r_ma[SW-1] ? r_ma : {r_ma[SW-2:0], 1'b0};
  assign w_mb_n = r_mb[SW-1] ? r_mb : {r_mb[SW-2:0], 1'b0};
  assign w_ea_n = r_ma[SW-1] ? r_ea : r_ea - EW'(1);
  assign w_eb_n = r_mb[SW-1] ? r_eb : r_eb - EW'(1);
  assign w_prod = PW'(r_ma) * PW'(r_mb);
  // Left-align the product so the significand always sits in the top SW bits.
  assign w_pn   = w_prod[PW-1] ? w_prod : {w_prod[PW-2:0], 1'b0};
  assign w_ez_m = r_ea + r_eb + (w_prod[PW-1] ? EW'(1) : EW'(0));

  // Denormalise, round
  logic                  w_shift, w_inc, w_grs, w_of, w_of_inf, w_nx, w_uf;
  logic [SW:0]           w_sum;
  logic [SW-1:0]         w_sig_r;
  logic signed [EW-1:0]  w_ez_r;
  logic [EXP_W-1:0]      w_exp_fld;
  logic [W-1:0]          w_round_z;

  assign w_shift = (r_ez < EMIN) && (r_cnt < CW'(CAP));
  assign w_grs   = r_g | r_r | r_s;

  always_comb begin
    w_inc = 1'b0;
    case (r_rm)
      2'd0:    w_inc = r_g & (r_r | r_s | r_sig[0]);
      2'd1:    w_inc = 1'b0;
      2'd2:    w_inc = r_sign & w_grs;
      default: w_inc = ~r_sign & w_grs;
    endcase
  end

  assign w_sum     = {1'b0, r_sig} + (SW+1)'(w_inc);
  assign w_sig_r   = w_sum[SW] ? w_sum[SW:1] : w_sum[SW-1:0];
  assign w_ez_r    = w_sum[SW] ? r_ez + EW'(1) : r_ez;
  assign w_of      = w_ez_r > BIAS;
  assign w_of_inf  = (r_rm == 2'd0) || (r_rm == 2'd2 && r_sign) || (r_rm == 2'd3 && !r_sign);
  assign w_nx      = w_grs | w_of;
  assign w_uf      = (r_cnt != '0) & w_grs & ~w_of;
  // A subnormal that rounds into the hidden bit has ez == EMIN and packs field 1.
  assign w_exp_fld = w_sig_r[SW-1] ? w_ez_r[EXP_W-1:0] + BIAS[EXP_W-1:0] : '0;

  always_comb begin
    w_round_z = {r_sign, w_exp_fld, w_sig_r[MAN_W-1:0]};
    if (w_of) begin
      if (w_of_inf) w_round_z = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      else          w_round_z = {r_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
    end
  end

  // FSM
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:   if (in_valid && r_in_ready) w_state_nxt = StUnpack;
      StUnpack: w_state_nxt = w_special ? StOut : StNorm;
      StNorm:   if (w_ma_n[SW-1] && w_mb_n[SW-1]) w_state_nxt = StMult;
      StMult:   w_state_nxt = StDenorm;
      StDenorm: if (!w_shift) w_state_nxt = StRound;
      StRound:  w_state_nxt = StOut;
      StOut:    if (out_ready) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt == StIdle);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_z     <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid && r_in_ready) begin
            r_a  <= in_a;
            r_b  <= in_b;
            r_rm <= in_rm;
          end
        end
        StUnpack: begin
          r_sign <= w_sign;
          r_ma   <= {|w_ea_fld, w_fa};
          r_mb   <= {|w_eb_fld, w_fb};
          r_ea   <= w_ea_unb;
          r_eb   <= w_eb_unb;
          if (w_special) begin
            r_z     <= w_special_z;
            r_flags <= w_special_f;
          end
        end
        StNorm: begin
          r_ma <= w_ma_n;
          r_mb <= w_mb_n;
          r_ea <= w_ea_n;
          r_eb <= w_eb_n;
        end
        StMult: begin
          r_sig <= w_pn[PW-1 -: SW];
          r_g   <= w_pn[SW-1];
          r_r   <= w_pn[SW-2];
          r_s   <= |w_pn[SW-3:0];
          r_ez  <= w_ez_m;
          r_cnt <= '0;
        end
        StDenorm: begin
          if (w_shift) begin
            r_sig <= r_sig >> 1;
            r_g   <= r_sig[0];
            r_r   <= r_g;
            r_s   <= r_s | r_r;
            r_ez  <= r_ez + EW'(1);
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StRound: begin
          r_z     <= w_round_z;
          r_flags <= {1'b0, w_of, w_uf, w_nx};
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == StOut);
  assign out_z     = r_z;
  assign out_flags = r_flags;

endmodule

// File: tb/tb_fp_mul_param.sv
// Self-checking bench for fp_mul_param (binary32): scoreboard of expected results,
// one task per scenario, latency measured from the accepting edge.
module tb_fp_mul_param;
  logic        clk;
  logic        rst;
  logic [31:0] in_a, in_b, out_z;
  logic [1:0]  in_rm;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  out_flags;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] z;
    logic [3:0]  f;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  fp_mul_param #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_rm     (in_rm),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_z     (out_z),
    .out_flags (out_flags),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Drive one operation and return #1 after the accepting edge; inputs are scrambled
  // afterwards so only the accept-edge values may matter.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                      output bit acc);
    in_a = a; in_b = b; in_rm = rm; in_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      if (in_ready === 1'b1) acc = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_rm = 2'($urandom);
  endtask

  task automatic collect(input bit consume, output logic [31:0] z, output logic [3:0] f,
                         output int lat, output bit to);
    lat = 1; to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (out_valid === 1'b1) begin
        to = 1'b0;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    lat--;
    z = out_z; f = out_flags;
    if (consume) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                       input logic [31:0] ez, input logic [3:0] ef, input int el);
    bit acc;
    sb_q.push_back('{z: ez, f: ef, lat: el});
    send(a, b, rm, acc);
    if (!acc) begin
      n_checks++; n_errors++;
      $display("FAIL accept: operation %h*%h never accepted", a, b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_rm = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++;
      $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (out_z !== 32'h0) begin n_errors++;
      $display("FAIL reset_out_z: got %h expected 0", out_z); end
    n_checks++; if (out_flags !== 4'h0) begin n_errors++;
      $display("FAIL reset_out_flags: got %h expected 0", out_flags); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++;
      $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++;
      $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
  endtask

  // Normal operands: 1.5*2 and rounding-mode dependence on an inexact product.
  task automatic test_normal();
    logic [31:0] va [3], vb [3], vz [3];
    logic [1:0]  vr [3];
    logic [3:0]  vf [3];
    logic [31:0] z; logic [3:0] f; int lat; bit to; exp_t e;
    va = '{32'h3FC00000, 32'h3F800001, 32'h3F800001};
    vb = '{32'h40000000, 32'h3F800001, 32'h3F800001};
    vr = '{2'd0, 2'd0, 2'd3};
    vz = '{32'h40400000, 32'h3F800002, 32'h3F800003};
    vf = '{4'h0, 4'h1, 4'h1};
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], vr[i], vz[i], vf[i], 5);
      collect(1'b1, z, f, lat, to);
      e = sb_q.pop_front();
      n_checks++; if (to || z !== e.z) begin n_errors++;
        $display("FAIL normal_z[%0d]: got %h expected %h timeout=%0b", i, z, e.z, to); end
      n_checks++; if (f !== e.f) begin n_errors++;
        $display("FAIL normal_flags[%0d]: got %h expected %h", i, f, e.f); end
      n_checks++; if (lat !== e.lat) begin n_errors++;
        $display("FAIL normal_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_specials();
    logic [31:0] va [3], vb [3], vz [3];
    logic [3:0]  vf [3];
    logic [31:0] z; logic [3:0] f; int lat; bit to; exp_t e;
    va = '{32'h7F800000, 32'h7F800001, 32'hFF800000};
    vb = '{32'h00000000, 32'h3F800000, 32'h3F800000};
    vz = '{32'h7FC00000, 32'h7FC00000, 32'hFF800000};
    vf = '{4'h8, 4'h8, 4'h0};
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], 2'd0, vz[i], vf[i], 1);
      collect(1'b1, z, f, lat, to);
      e = sb_q.pop_front();
      n_checks++; if (to || z !== e.z) begin n_errors++;
        $display("FAIL special_z[%0d]: got %h expected %h timeout=%0b", i, z, e.z, to); end
      n_checks++; if (f !== e.f) begin n_errors++;
        $display("FAIL special_flags[%0d]: got %h expected %h", i, f, e.f); end
      n_checks++; if (lat !== e.lat) begin n_errors++;
        $display("FAIL special_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] vb [3], vz [3];
    logic [1:0]  vr [3];
    logic [31:0] z; logic [3:0] f; int lat; bit to; exp_t e;
    vb = '{32'h40000000, 32'h40000000, 32'hC0000000};
    vr = '{2'd0, 2'd1, 2'd3};
    vz = '{32'h7F800000, 32'h7F7FFFFF, 32'hFF7FFFFF};
    for (int i = 0; i < 3; i++) begin
      issue(32'h7F7FFFFF, vb[i], vr[i], vz[i], 4'h5, 5);
      collect(1'b1, z, f, lat, to);
      e = sb_q.pop_front();
      n_checks++; if (to || z !== e.z) begin n_errors++;
        $display("FAIL overflow_z[%0d]: got %h expected %h timeout=%0b", i, z, e.z, to); end
      n_checks++; if (f !== e.f) begin n_errors++;
        $display("FAIL overflow_flags[%0d]: got %h expected %h", i, f, e.f); end
      n_checks++; if (lat !== e.lat) begin n_errors++;
        $display("FAIL overflow_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_subnormal();
    logic [31:0] va [2], vb [2], vz [2];
    logic [3:0]  vf [2];
    int          vl [2];
    logic [31:0] z; logic [3:0] f; int lat; bit to; exp_t e;
    va = '{32'h00000001, 32'h00800001};
    vb = '{32'h3F800000, 32'h3F000000};
    vz = '{32'h00000001, 32'h00400000};
    vf = '{4'h0, 4'h3};
    vl = '{50, 6};
    for (int i = 0; i < 2; i++) begin
      issue(va[i], vb[i], 2'd0, vz[i], vf[i], vl[i]);
      collect(1'b1, z, f, lat, to);
      e = sb_q.pop_front();
      n_checks++; if (to || z !== e.z) begin n_errors++;
        $display("FAIL subnormal_z[%0d]: got %h expected %h timeout=%0b", i, z, e.z, to); end
      n_checks++; if (f !== e.f) begin n_errors++;
        $display("FAIL subnormal_flags[%0d]: got %h expected %h", i, f, e.f); end
      n_checks++; if (lat !== e.lat) begin n_errors++;
        $display("FAIL subnormal_latency[%0d]: got %0d expected %0d", i, lat, e.lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] z; logic [3:0] f; int lat; bit to; exp_t e;
    out_ready = 1'b0;
    issue(32'h3FC00000, 32'h40000000, 2'd0, 32'h40400000, 4'h0, 5);
    collect(1'b0, z, f, lat, to);
    e = sb_q.pop_front();
    n_checks++; if (to || z !== e.z) begin n_errors++;
      $display("FAIL b2b_first_z: got %h expected %h timeout=%0b", z, e.z, to); end
    // Second operation waits while the first result is stalled.
    in_a = 32'h40000000; in_b = 32'h40400000; in_rm = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_z !== e.z) begin
        n_errors++;
        $display("FAIL b2b_hold[%0d]: got ready=%b valid=%b z=%h expected 0 1 %h",
                 i, in_ready, out_valid, out_z, e.z);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_z !== e.z) begin
      n_errors++;
      $display("FAIL b2b_handshake: got valid=%b ready=%b z=%h expected 0 1 %h",
               out_valid, in_ready, out_z, e.z);
    end
    sb_q.push_back('{z: 32'h40C00000, f: 4'h0, lat: 5});
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_rm = 2'($urandom);
    n_checks++; if (in_ready !== 1'b0) begin n_errors++;
      $display("FAIL b2b_second_accept: got in_ready=%b expected 0", in_ready); end
    collect(1'b1, z, f, lat, to);
    e = sb_q.pop_front();
    n_checks++; if (to || z !== e.z) begin n_errors++;
      $display("FAIL b2b_second_z: got %h expected %h timeout=%0b", z, e.z, to); end
    n_checks++; if (lat !== e.lat) begin n_errors++;
      $display("FAIL b2b_second_latency: got %0d expected %0d", lat, e.lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] z; logic [3:0] f; int lat; bit to; exp_t e; bit acc; bit seen;
    send(32'h00000001, 32'h3F800000, 2'd0, acc);
    repeat (28) begin @(posedge clk); #1; end
    n_checks++; if (!acc || out_valid !== 1'b0) begin n_errors++;
      $display("FAIL mid_pre_reset: got accepted=%b valid=%b expected 1 0", acc, out_valid); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_z !== 32'h0 ||
                    out_flags !== 4'h0) begin
      n_errors++;
      $display("FAIL mid_reset_outputs: got valid=%b ready=%b z=%h flags=%h expected all 0",
               out_valid, in_ready, out_z, out_flags);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (60) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_checks++; if (seen || in_ready !== 1'b1) begin n_errors++;
      $display("FAIL mid_reset_discard: got stray_valid=%b ready=%b expected 0 1",
               seen, in_ready);
    end
    issue(32'h3FC00000, 32'h40000000, 2'd0, 32'h40400000, 4'h0, 5);
    collect(1'b1, z, f, lat, to);
    e = sb_q.pop_front();
    n_checks++; if (to || z !== e.z) begin n_errors++;
      $display("FAIL mid_after_z: got %h expected %h timeout=%0b", z, e.z, to); end
    n_checks++; if (f !== e.f) begin n_errors++;
      $display("FAIL mid_after_flags: got %h expected %h", f, e.f); end
    n_checks++; if (lat !== e.lat) begin n_errors++;
      $display("FAIL mid_after_latency: got %0d expected %0d", lat, e.lat); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_specials();
    test_overflow();
    test_subnormal();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
